// File: rtl/array_port_arb.sv
// Purpose : two-requester round-robin arbiter for one masked 256x168 array port, with clear walk.
// Latency : grant is combinational; read data returns on respN one cycle after the grant.
// Backpr. : reqN_ready low while clearing or when losing arbitration; responses cannot stall.
//
// Ports: clock/reset_n (async active-low); init_req/init_done control the clear walk;
//        req0_*/req1_* valid-ready request channels; resp0_*/resp1_* read returns;
//        mem_* drive the array port, mem_rdata returns data one cycle after a read enable.
// Optional: define ARRAY_PORT_ARB_PERF_EN to add perf_grant0/perf_grant1/perf_conflict counters.
module array_port_arb #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int DATA_W = 168,
  parameter int MASK_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              init_req,
  output logic              init_done,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [MASK_W-1:0] req0_wmask,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [MASK_W-1:0] req1_wmask,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,
  output logic              mem_en,
  output logic              mem_wmode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [MASK_W-1:0] mem_wmask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARRAY_PORT_ARB_PERF_EN
  ,
  output logic [31:0]       perf_grant0,
  output logic [31:0]       perf_grant1,
  output logic [31:0]       perf_conflict
`endif
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic              rr_ptr;
  logic              rd_owner;

  logic              in_run;
  logic              contested;
  logic              gnt_vld;
  logic              gnt_idx;
  logic              gnt_write;
  logic [ADDR_W-1:0] gnt_addr;
  logic [MASK_W-1:0] gnt_wmask;
  logic [DATA_W-1:0] gnt_wdata;

  // Reset gating keeps the array port and ready lines quiet while reset_n is low.
  assign in_run    = reset_n && (state == ST_RUN);
  assign contested = req0_valid && req1_valid;
  assign gnt_vld   = in_run && (req0_valid || req1_valid);
  // Contested: pointer decides. Uncontested: whichever one is valid (req1 iff req0 idle).
  assign gnt_idx   = contested ? rr_ptr : req1_valid;

  always_comb begin
    gnt_write = gnt_idx ? req1_write : req0_write;
    gnt_addr  = gnt_idx ? req1_addr  : req0_addr;
    gnt_wmask = gnt_idx ? req1_wmask : req0_wmask;
    gnt_wdata = gnt_idx ? req1_wdata : req0_wdata;
  end

  assign req0_ready = gnt_vld && !gnt_idx;
  assign req1_ready = gnt_vld &&  gnt_idx;

  always_comb begin
    mem_en    = 1'b0;
    mem_wmode = 1'b0;
    mem_addr  = '0;
    mem_wmask = '0;
    mem_wdata = '0;
    if (reset_n && state == ST_INIT) begin
      mem_en    = 1'b1;
      mem_wmode = 1'b1;
      mem_addr  = clr_addr;
      mem_wmask = '1;
    end else if (gnt_vld) begin
      mem_en    = 1'b1;
      mem_wmode = gnt_write;
      mem_addr  = gnt_addr;
      mem_wmask = gnt_wmask;
      mem_wdata = gnt_wdata;
    end
  end

  // The array presents read data one cycle after the enable; steer it to the issuer only.
  assign resp0_rdata = (resp0_valid && !rd_owner) ? mem_rdata : '0;
  assign resp1_rdata = (resp1_valid &&  rd_owner) ? mem_rdata : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_INIT;
      clr_addr    <= '0;
      rr_ptr      <= 1'b0;
      init_done   <= 1'b0;
      rd_owner    <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
    end else begin
      // Responses are registered regardless of next state, so a read granted
      // alongside init_req still returns in the first clear cycle.
      resp0_valid <= gnt_vld && !gnt_write && !gnt_idx;
      resp1_valid <= gnt_vld && !gnt_write &&  gnt_idx;
      if (gnt_vld && !gnt_write) begin
        rd_owner <= gnt_idx;
      end
      case (state)
        ST_INIT: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == ADDR_W'(DEPTH - 1)) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          if (contested) begin
            rr_ptr <= ~gnt_idx;
          end
          if (init_req) begin
            state     <= ST_INIT;
            clr_addr  <= '0;
            init_done <= 1'b0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

`ifdef ARRAY_PORT_ARB_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_grant0   <= '0;
      perf_grant1   <= '0;
      perf_conflict <= '0;
    end else if (in_run && init_req) begin
      // Entering the clear walk restarts the statistics.
      perf_grant0   <= '0;
      perf_grant1   <= '0;
      perf_conflict <= '0;
    end else if (in_run) begin
      if (req0_ready && perf_grant0 != 32'hFFFF_FFFF) begin
        perf_grant0 <= perf_grant0 + 32'd1;
      end
      if (req1_ready && perf_grant1 != 32'hFFFF_FFFF) begin
        perf_grant1 <= perf_grant1 + 32'd1;
      end
      if (contested && perf_conflict != 32'hFFFF_FFFF) begin
        perf_conflict <= perf_conflict + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_array_port_arb.sv
// Purpose : bench for array_port_arb; emulates the array and checks against a transaction-level model.
// Latency : model predicts every output each cycle from its own shadow memory and arbitration rules.
// Backpr. : requesters always sink responses; stimulus is random plus directed scenarios.
module tb_array_port_arb;
  localparam int DW = 168;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          init_req;
  logic          init_done;
  logic          rv [2];
  logic          rw [2];
  logic [7:0]    ra [2];
  logic [7:0]    rm [2];
  logic [DW-1:0] rd [2];
  logic          req0_ready, req1_ready;
  logic          resp0_valid, resp1_valid;
  logic [DW-1:0] resp0_rdata, resp1_rdata;
  logic          mem_en, mem_wmode;
  logic [7:0]    mem_addr, mem_wmask;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef ARRAY_PORT_ARB_PERF_EN
  logic [31:0]   perf_grant0, perf_grant1, perf_conflict;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  array_port_arb dut (
    .clock(clock), .reset_n(reset_n), .init_req(init_req), .init_done(init_done),
    .req0_valid(rv[0]), .req0_ready(req0_ready), .req0_write(rw[0]), .req0_addr(ra[0]),
    .req0_wmask(rm[0]), .req0_wdata(rd[0]),
    .req1_valid(rv[1]), .req1_ready(req1_ready), .req1_write(rw[1]), .req1_addr(ra[1]),
    .req1_wmask(rm[1]), .req1_wdata(rd[1]),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
    .mem_en(mem_en), .mem_wmode(mem_wmode), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARRAY_PORT_ARB_PERF_EN
    , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_conflict(perf_conflict)
`endif
  );

  function automatic logic [DW-1:0] apply_mask(logic [DW-1:0] old, logic [DW-1:0] nw, logic [7:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int s = 0; s < 8; s++) begin
      if (m[s]) r[s*21 +: 21] = nw[s*21 +: 21];
    end
    return r;
  endfunction

  // Array emulation: synchronous masked write, read data registered one cycle after enable.
  logic [DW-1:0] arr [256];
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_wmode) arr[mem_addr] <= apply_mask(arr[mem_addr], mem_wdata, mem_wmask);
      else           mem_rdata     <= arr[mem_addr];
    end
  end

  // Behavioural model state.
  logic [DW-1:0] shadow [256];
  bit            m_init;
  int            m_clr, m_rr, m_pend;
  bit            m_done;
  logic [DW-1:0] m_pdata;
  int            pg0, pg1, pc;

  // Samples from the last compare, used by directed checks.
  logic          s_rdy0, s_rdy1, s_done, s_r0v, s_r1v, s_men;
  logic [DW-1:0] s_r0d;
  logic [7:0]    s_maddr;

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_init = 1; m_clr = 0; m_rr = 0; m_done = 0; m_pend = -1; m_pdata = '0;
    pg0 = 0; pg1 = 0; pc = 0;
  endtask

  function automatic int sat_inc(int v);
    return (v == -1) ? v : v + 1;
  endfunction

  // One clock: predict, compare at negedge, advance model at posedge.
  task automatic cycle();
    int            g, np;
    logic          e_en, e_wm;
    logic [7:0]    e_addr, e_mask;
    logic [DW-1:0] e_wd, npd;
    g = -1; e_en = 0; e_wm = 0; e_addr = 0; e_mask = 0; e_wd = '0; np = -1; npd = '0;
    if (reset_n) begin
      if (m_init) begin
        e_en = 1; e_wm = 1; e_addr = 8'(m_clr); e_mask = 8'hFF;
      end else begin
        if (rv[0] && rv[1]) g = m_rr;
        else if (rv[0])     g = 0;
        else if (rv[1])     g = 1;
        if (g >= 0) begin
          e_en = 1; e_wm = rw[g]; e_addr = ra[g]; e_mask = rm[g]; e_wd = rd[g];
        end
      end
    end
    @(negedge clock);
    chk("ready0", DW'(req0_ready), DW'(g == 0));
    chk("ready1", DW'(req1_ready), DW'(g == 1));
    chk("mem_en", DW'(mem_en), DW'(e_en));
    chk("mem_wmode", DW'(mem_wmode), DW'(e_wm));
    chk("mem_addr", DW'(mem_addr), DW'(e_addr));
    chk("mem_wmask", DW'(mem_wmask), DW'(e_mask));
    chk("mem_wdata", mem_wdata, e_wd);
    chk("init_done", DW'(init_done), DW'(m_done));
    chk("resp0_valid", DW'(resp0_valid), DW'(m_pend == 0));
    chk("resp1_valid", DW'(resp1_valid), DW'(m_pend == 1));
    chk("resp0_rdata", resp0_rdata, (m_pend == 0) ? m_pdata : '0);
    chk("resp1_rdata", resp1_rdata, (m_pend == 1) ? m_pdata : '0);
`ifdef ARRAY_PORT_ARB_PERF_EN
    chk("perf_grant0", DW'(perf_grant0), DW'(32'(pg0)));
    chk("perf_grant1", DW'(perf_grant1), DW'(32'(pg1)));
    chk("perf_conflict", DW'(perf_conflict), DW'(32'(pc)));
`endif
    s_rdy0 = req0_ready; s_rdy1 = req1_ready; s_done = init_done;
    s_r0v = resp0_valid; s_r1v = resp1_valid; s_r0d = resp0_rdata;
    s_men = mem_en; s_maddr = mem_addr;
    @(posedge clock);
    if (reset_n) begin
      if (!m_init && g >= 0 && !rw[g]) begin
        np = g; npd = shadow[ra[g]];
      end
      if (m_init) begin
        shadow[m_clr] = '0;
        if (m_clr == 255) begin m_init = 0; m_done = 1; end
        m_clr = (m_clr + 1) % 256;
      end else begin
        if (g == 0) pg0 = sat_inc(pg0);
        if (g == 1) pg1 = sat_inc(pg1);
        if (rv[0] && rv[1]) begin pc = sat_inc(pc); m_rr = 1 - g; end
        if (g >= 0 && rw[g]) shadow[ra[g]] = apply_mask(shadow[ra[g]], rd[g], rm[g]);
        if (init_req) begin
          m_init = 1; m_clr = 0; m_done = 0; pg0 = 0; pg1 = 0; pc = 0;
        end
      end
      m_pend = np; m_pdata = npd;
    end
    #1;
  endtask

  task automatic idle_inputs();
    init_req = 0;
    for (int k = 0; k < 2; k++) begin
      rv[k] = 0; rw[k] = 0; ra[k] = 0; rm[k] = 0; rd[k] = '0;
    end
  endtask

  task automatic rand_inputs();
    logic [191:0] t;
    init_req = ($urandom_range(0, 99) == 0);
    for (int k = 0; k < 2; k++) begin
      t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rv[k] = 1'($urandom_range(0, 1));
      rw[k] = 1'($urandom_range(0, 1));
      ra[k] = 8'($urandom_range(0, 7));
      rm[k] = 8'($urandom);
      rd[k] = t[DW-1:0];
    end
  endtask

  // Counts sampled cycles with init_done low until it rises (bounded).
  task automatic count_init(output int n, output logic first_r0v);
    n = 0; first_r0v = 0;
    for (int i = 0; i < 300; i++) begin
      cycle();
      if (i == 0) first_r0v = s_r0v;
      if (s_done) break;
      n++;
    end
  endtask

  initial begin
    int         n;
    logic       fr;
    logic [7:0] pat;
    logic [DW-1:0] ones;
    ones = '1;
    for (int i = 0; i < 256; i++) begin
      arr[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      shadow[i] = arr[i];
    end
    mem_rdata = '0;
    reset_n = 0;
    idle_inputs();
    model_reset();
    #1;
    repeat (3) cycle();
    chk("reset_init_done", DW'(s_done), '0);
    chk("reset_mem_en", DW'(s_men), '0);
    reset_n = 1;

    // Power-on clear: 256 cycles with init_done low.
    count_init(n, fr);
    chk("power_on_clear_len", DW'(n), DW'(256));

    // Masked write then read back through req0.
    rv[0] = 1; rw[0] = 1; ra[0] = 8'h12; rm[0] = 8'h01; rd[0] = ones;
    cycle();
    rw[0] = 0;
    cycle();
    rv[0] = 0;
    cycle();
    chk("masked_rdata", s_r0d, 168'h1FFFFF);
    chk("masked_resp1_idle", DW'(s_r1v), '0);

    // Contested reads alternate starting with req0.
    rv[0] = 1; rv[1] = 1; rw[0] = 0; rw[1] = 0; ra[0] = 8'h01; ra[1] = 8'h02;
    for (int i = 0; i < 8; i++) begin
      cycle();
      pat[i] = s_rdy1;
    end
    chk("alternate_grants", DW'(pat), DW'(8'hAA));

    // Uncontested req1 grants leave the pointer alone.
    rv[0] = 0; n = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (s_rdy1) n++;
    end
    chk("req1_solo_grants", DW'(n), DW'(4));
    rv[0] = 1;
    cycle();
    chk("first_contest_after_solo", DW'(s_rdy0), DW'(1));

    // init_req alongside a granted read.
    rv[1] = 0; ra[0] = 8'h12; init_req = 1;
    cycle();
    init_req = 0; rv[0] = 0;
    count_init(n, fr);
    chk("init_req_resp0", DW'(fr), DW'(1));
    chk("init_req_clear_len", DW'(n), DW'(256));
    rv[0] = 1;
    cycle();
    rv[0] = 0;
    cycle();
    chk("cleared_entry", s_r0d, '0);

    // Reset while a read response is outstanding.
    rv[0] = 1;
    cycle();
    reset_n = 0;
    #1;
    chk("rst_resp0_drop", DW'(resp0_valid), '0);
    chk("rst_mem_en", DW'(mem_en), '0);
    chk("rst_ready0", DW'(req0_ready), '0);
    model_reset();
    rv[0] = 0;
    repeat (2) cycle();
    reset_n = 1;
    cycle();
    chk("walk_restart_addr", DW'(s_maddr), '0);
    chk("walk_restart_en", DW'(s_men), DW'(1));
`ifdef ARRAY_PORT_ARB_PERF_EN
    chk("perf_zero_after_rst", DW'({perf_grant0, perf_grant1, perf_conflict}), '0);
`endif

    // Random traffic with occasional re-clears.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
